// File: rtl/sha256_core_arbiter.sv
// Round-robin arbiter sharing one SHA-256 core among NUM_REQ requesters, one job in flight.
// Optional WAIT timeout with core abort pulse: define SHA256_ARB_TIMEOUT_EN.
module sha256_core_arbiter #(
    parameter  int NUM_REQ        = 4,
    parameter  int TIMEOUT_CYCLES = 80,
    localparam int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   en_i,
    input  logic [NUM_REQ-1:0]     req_v_i,
    input  logic [NUM_REQ*256-1:0] req_msg_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   resp_v_o,
    output logic [ID_W-1:0]        resp_id_o,
    output logic [255:0]           resp_digest_o,
    output logic                   resp_err_o,
    input  logic                   resp_yumi_i,
    output logic                   core_v_o,
    output logic [255:0]           core_msg_o,
    input  logic                   core_ready_i,
    input  logic                   core_v_i,
    input  logic [255:0]           core_digest_i,
    output logic                   core_yumi_o,
    output logic                   core_reset_o
);

    // state | meaning
    // IDLE  | waiting for an enabled request, grants round-robin
    // ISSUE | presenting latched message until core accepts it
    // WAIT  | core hashing; waiting for its digest (or timeout)
    // RESP  | holding the tagged digest until the consumer takes it
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("sha256_core_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id_q;
    logic [255:0]    msg_q;
    logic [255:0]    digest_q;
    logic [ID_W-1:0] grant_id;
    logic            grant_found;
    logic            grant_fire;
    logic [ID_W:0]   cand_sum;
    logic [255:0]    msg_sel;

    // Search starts one past the last served requester, wrapping at NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand_sum    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand_sum >= (ID_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_v_i[cand_sum[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand_sum[ID_W-1:0];
            end
        end
    end

    assign grant_fire = (state == ST_IDLE) && en_i && grant_found;
    assign msg_sel    = req_msg_i[grant_id*256 +: 256];

`ifdef SHA256_ARB_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMR_W-1:0] timer;
    logic             err_q;
    logic             tmo_hit;

    assign tmo_hit = (state == ST_WAIT) && (timer == TMR_W'(TIMEOUT_CYCLES-1));
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        req_ready_o  = '0;
        core_v_o     = 1'b0;
        core_yumi_o  = 1'b0;
        resp_v_o     = 1'b0;
        core_reset_o = 1'b0;
        case (state)
            ST_IDLE: begin
                // Gated by reset so the accept strobe is silent while reset is held.
                if (grant_fire && reset_n_i) begin
                    req_ready_o[grant_id] = 1'b1;
                end
                if (grant_fire) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                core_v_o = 1'b1;
                if (core_ready_i) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_v_i) begin
                    core_yumi_o = 1'b1;
                    state_next  = ST_RESP;
                end
`ifdef SHA256_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    core_reset_o = 1'b1;
                    state_next   = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                resp_v_o = 1'b1;
                if (resp_yumi_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            msg_q    <= '0;
            id_q     <= '0;
            digest_q <= '0;
            rr_ptr   <= ID_W'(NUM_REQ-1);
        end else begin
            if (grant_fire) begin
                msg_q <= msg_sel;
                id_q  <= grant_id;
            end
            if (core_yumi_o) begin
                digest_q <= core_digest_i;
            end
`ifdef SHA256_ARB_TIMEOUT_EN
            else if (core_reset_o) begin
                digest_q <= '0;
            end
`endif
            if (state == ST_RESP && resp_yumi_i) begin
                rr_ptr <= id_q;
            end
        end
    end

`ifdef SHA256_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            timer <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == ST_ISSUE && core_ready_i) begin
                timer <= '0;
            end else if (state == ST_WAIT && !core_v_i && !tmo_hit) begin
                timer <= timer + TMR_W'(1);
            end
            if (core_yumi_o) begin
                err_q <= 1'b0;
            end else if (core_reset_o) begin
                err_q <= 1'b1;
            end
        end
    end

    assign resp_err_o = err_q;
`else
    assign resp_err_o = 1'b0;
`endif

    assign core_msg_o    = msg_q;
    assign resp_id_o     = id_q;
    assign resp_digest_o = digest_q;

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Self-checking bench for sha256_core_arbiter: directed job table, corner sequences, random vs. reference model.
module tb_sha256_core_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int TIMEOUT_CYCLES = 80;

    logic          clk_i;
    logic          reset_n_i;
    logic          en_i;
    logic [3:0]    req_v_i;
    logic [1023:0] req_msg_i;
    logic [3:0]    req_ready_o;
    logic          resp_v_o;
    logic [1:0]    resp_id_o;
    logic [255:0]  resp_digest_o;
    logic          resp_err_o;
    logic          resp_yumi_i;
    logic          core_v_o;
    logic [255:0]  core_msg_o;
    logic          core_ready_i;
    logic          core_v_i;
    logic [255:0]  core_digest_i;
    logic          core_yumi_o;
    logic          core_reset_o;

    sha256_core_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .en_i          (en_i),
        .req_v_i       (req_v_i),
        .req_msg_i     (req_msg_i),
        .req_ready_o   (req_ready_o),
        .resp_v_o      (resp_v_o),
        .resp_id_o     (resp_id_o),
        .resp_digest_o (resp_digest_o),
        .resp_err_o    (resp_err_o),
        .resp_yumi_i   (resp_yumi_i),
        .core_v_o      (core_v_o),
        .core_msg_o    (core_msg_o),
        .core_ready_i  (core_ready_i),
        .core_v_i      (core_v_i),
        .core_digest_i (core_digest_i),
        .core_yumi_o   (core_yumi_o),
        .core_reset_o  (core_reset_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    logic [255:0] cur_msg [4];

    typedef struct {
        logic [3:0] rv;
        int         exp_id;
        int         rdy_dly;
        int         core_dly;
        int         yumi_dly;
        bit         drop_en;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic load_msgs();
        for (int r = 0; r < 4; r++) begin
            cur_msg[r] = rand256();
            req_msg_i[r*256 +: 256] = cur_msg[r];
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_n_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    // One complete job with configurable stalls on each handshake.
    task automatic run_job(input logic [3:0] rv, input int exp_id, input int rdy_dly,
                           input int core_dly, input int yumi_dly, input bit drop_en);
        logic [255:0] msg;
        logic [255:0] dig;
        logic [3:0]   oh;
        oh  = 4'b0001 << exp_id;
        dig = rand256();
        load_msgs();
        req_v_i = rv;
        en_i    = 1'b1;
        #1;
        check("grant", req_ready_o, oh);
        msg = cur_msg[exp_id];
        @(negedge clk_i);
        load_msgs();
        for (int i = 0; i <= rdy_dly; i++) begin
            core_ready_i = (i == rdy_dly);
            #1;
            check("issue_v", core_v_o, 1);
            check("issue_msg", core_msg_o, msg);
            check("issue_noready", req_ready_o, 0);
            @(negedge clk_i);
        end
        core_ready_i = 1'b0;
        if (drop_en) en_i = 1'b0;
        for (int i = 0; i <= core_dly; i++) begin
            core_v_i      = (i == core_dly);
            core_digest_i = core_v_i ? dig : rand256();
            #1;
            check("wait_yumi", core_yumi_o, core_v_i);
            check("wait_core_v", core_v_o, 0);
            check("wait_resp_v", resp_v_o, 0);
            check("wait_noready", req_ready_o, 0);
            @(negedge clk_i);
        end
        core_v_i      = 1'b0;
        core_digest_i = rand256();
        for (int i = 0; i <= yumi_dly; i++) begin
            resp_yumi_i = (i == yumi_dly);
            #1;
            check("resp_v", resp_v_o, 1);
            check("resp_id", resp_id_o, exp_id);
            check("resp_digest", resp_digest_o, dig);
            check("resp_err", resp_err_o, 0);
            check("resp_noready", req_ready_o, 0);
            @(negedge clk_i);
        end
        resp_yumi_i = 1'b0;
        #1;
        check("idle_resp_v", resp_v_o, 0);
        check("next_grant", (req_ready_o != 0), (!drop_en && rv != 0));
        req_v_i = '0;
        en_i    = 1'b1;
    endtask

    // Job whose digest arrives deliver_at cycles into WAIT (never if negative).
    task automatic stall_job(input int deliver_at);
        logic [255:0] dig;
        int pulses;
        int pulse_at;
        bit done;
        dig      = rand256();
        pulses   = 0;
        pulse_at = -1;
        done     = 1'b0;
        load_msgs();
        req_v_i = 4'b0001;
        en_i    = 1'b1;
        #1;
        check("stall_grant", req_ready_o, 4'b0001);
        @(negedge clk_i);
        req_v_i      = '0;
        core_ready_i = 1'b1;
        #1;
        check("stall_issue", core_v_o, 1);
        @(negedge clk_i);
        core_ready_i = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            core_v_i      = (k == deliver_at);
            core_digest_i = core_v_i ? dig : rand256();
            #1;
            if (resp_v_o) begin
                done = 1'b1;
            end else begin
                if (core_reset_o) begin
                    pulses++;
                    if (pulse_at < 0) pulse_at = k;
                end
                if (core_v_i) check("stall_yumi", core_yumi_o, 1);
            end
            if (!done) @(negedge clk_i);
        end
        core_v_i = 1'b0;
        check("stall_pulses", pulses, (deliver_at < 0) ? 1 : 0);
        if (deliver_at < 0) check("stall_pulse_at", pulse_at, TIMEOUT_CYCLES-1);
        check("stall_resp_v", resp_v_o, 1);
        check("stall_resp_id", resp_id_o, 0);
        check("stall_resp_err", resp_err_o, (deliver_at < 0) ? 1 : 0);
        check("stall_resp_digest", resp_digest_o, (deliver_at < 0) ? 256'd0 : dig);
        resp_yumi_i = 1'b1;
        @(negedge clk_i);
        resp_yumi_i = 1'b0;
        #1;
        check("stall_idle", resp_v_o, 0);
    endtask

    // Random traffic against a transaction-level model of one job's life.
    task automatic random_test(input int cycles);
        int ph;
        int ptr;
        int cdly;
        int mid;
        int win;
        int c;
        bit cval;
        logic [255:0] exp_msg;
        logic [255:0] exp_dig;
        logic [255:0] cdig;
        logic [3:0]   rv;
        logic [3:0]   exp_rdy;
        ph = 0; ptr = NUM_REQ-1; cdly = 0; mid = 0; cval = 1'b0;
        exp_msg = '0; exp_dig = '0; cdig = '0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(negedge clk_i);
            rv           = 4'($urandom_range(0, 15));
            req_v_i      = rv;
            en_i         = ($urandom_range(0, 9) != 0);
            load_msgs();
            core_ready_i = 1'($urandom_range(0, 1));
            resp_yumi_i  = ($urandom_range(0, 2) == 0);
            if (ph == 2) begin
                if (!cval) begin
                    if (cdly == 0) cval = 1'b1;
                    else cdly--;
                end
                core_v_i      = cval;
                core_digest_i = cval ? cdig : rand256();
            end else begin
                core_v_i      = ($urandom_range(0, 5) == 0);
                core_digest_i = rand256();
            end
            #1;
            win = -1;
            if (ph == 0 && en_i) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    c = (ptr + k) % NUM_REQ;
                    if (win < 0 && rv[2'(c)]) win = c;
                end
            end
            exp_rdy = (win >= 0) ? (4'b0001 << win) : 4'b0000;
            check("rnd_ready", req_ready_o, exp_rdy);
            check("rnd_core_v", core_v_o, (ph == 1));
            if (ph == 1) check("rnd_core_msg", core_msg_o, exp_msg);
            check("rnd_core_yumi", core_yumi_o, (ph == 2) && core_v_i);
            check("rnd_resp_v", resp_v_o, (ph == 3));
            if (ph == 3) begin
                check("rnd_resp_id", resp_id_o, mid);
                check("rnd_resp_digest", resp_digest_o, exp_dig);
                check("rnd_resp_err", resp_err_o, 0);
            end
            check("rnd_core_reset", core_reset_o, 0);
            case (ph)
                0: if (win >= 0) begin exp_msg = cur_msg[win]; mid = win; ph = 1; end
                1: if (core_ready_i) begin
                       ph = 2; cdig = rand256(); cdly = $urandom_range(0, 6); cval = 1'b0;
                   end
                2: if (cval) begin ph = 3; exp_dig = cdig; cval = 1'b0; end
                default: if (resp_yumi_i) begin ptr = mid; ph = 0; end
            endcase
        end
        req_v_i = '0; resp_yumi_i = 1'b0; core_v_i = 1'b0; core_ready_i = 1'b0; en_i = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_i     = 1'b0;
        en_i          = 1'b1;
        req_v_i       = '0;
        req_msg_i     = '0;
        resp_yumi_i   = 1'b0;
        core_ready_i  = 1'b0;
        core_v_i      = 1'b0;
        core_digest_i = '0;

        vecs[0] = '{4'b0100, 2, 0, 0, 0, 1'b0};
        vecs[1] = '{4'b1111, 3, 5, 2, 10, 1'b0};
        vecs[2] = '{4'b1111, 0, 0, 0, 0, 1'b0};
        vecs[3] = '{4'b0110, 1, 1, 3, 1, 1'b1};
        vecs[4] = '{4'b0001, 0, 0, 1, 0, 1'b0};
        vecs[5] = '{4'b1000, 3, 2, 0, 2, 1'b0};
        vecs[6] = '{4'b1001, 0, 0, 4, 0, 1'b0};
        vecs[7] = '{4'b1010, 1, 0, 0, 3, 1'b0};
        vecs[8] = '{4'b1010, 3, 3, 1, 0, 1'b0};
        vecs[9] = '{4'b0011, 0, 0, 0, 0, 1'b0};

        @(negedge clk_i);
        req_v_i = 4'b1111;
        #1;
        check("rst_ctrl", {req_ready_o, resp_v_o, resp_id_o, resp_err_o, core_v_o, core_yumi_o, core_reset_o}, 0);
        check("rst_data", core_msg_o | resp_digest_o, 0);
        req_v_i = '0;
        @(negedge clk_i);
        reset_n_i = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_job(vecs[i].rv, vecs[i].exp_id, vecs[i].rdy_dly, vecs[i].core_dly,
                    vecs[i].yumi_dly, vecs[i].drop_en);
        end

        req_v_i = 4'b1111;
        en_i    = 1'b0;
        load_msgs();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("en_low_noready", req_ready_o, 0);
            @(negedge clk_i);
        end
        #1;
        check("en_low_no_issue", core_v_o, 0);
        req_v_i = '0;
        en_i    = 1'b1;

        do_reset();
        for (int j = 0; j < 8; j++) begin
            run_job(4'b1111, j % NUM_REQ, 0, 0, 0, 1'b0);
        end

        load_msgs();
        req_v_i = 4'b1111;
        en_i    = 1'b1;
        @(negedge clk_i);
        req_v_i      = '0;
        core_ready_i = 1'b1;
        @(negedge clk_i);
        core_ready_i = 1'b0;
        req_v_i      = 4'b1111;
        #1;
        check("midwait_core_v", core_v_o, 0);
        reset_n_i = 1'b0;
        #1;
        check("midrst_ctrl", {req_ready_o, resp_v_o, resp_id_o, resp_err_o, core_v_o, core_yumi_o, core_reset_o}, 0);
        check("midrst_data", core_msg_o | resp_digest_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #1;
        check("postrst_grant", req_ready_o, 4'b0001);
        req_v_i = '0;
        @(negedge clk_i);
        #1;
        check("postrst_no_resp", resp_v_o, 0);
        check("postrst_no_issue", core_v_o, 0);

`ifdef SHA256_ARB_TIMEOUT_EN
        stall_job(-1);
        stall_job(TIMEOUT_CYCLES-1);
`else
        stall_job(150);
`endif

        do_reset();
        random_test(3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
